// File: rtl/fifo_vga_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_vga_reader
// Description : VGA raster generator that drains a show-ahead pixel FIFO, one
//               word per visible pixel, blanking and resyncing on underflow.
//               Optional build macro UNDERFLOW_CNT_EN adds a saturating
//               16-bit underflow_count_out port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_vga_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_in,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_empty_in,
    output logic                  fifo_rd_ack_out,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  active_out,
    output logic                  frame_start_out,
    output logic                  underflow_out
`ifdef UNDERFLOW_CNT_EN
    ,
    output logic [15:0]           underflow_count_out
`endif
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_WIDTH-1:0] c_H_MAX    = CNT_WIDTH'(c_H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] c_V_MAX    = CNT_WIDTH'(c_V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] c_H_ACT    = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] c_V_ACT    = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] c_HS_BEGIN = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] c_HS_END   = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] c_VS_BEGIN = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] c_VS_END   = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_SYNC_WAIT = 2'd1;
    localparam logic [1:0] c_RUN       = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [CNT_WIDTH-1:0] r_h_cnt;
    logic [CNT_WIDTH-1:0] r_v_cnt;
    logic                 w_vis;
    logic                 w_hs;
    logic                 w_vs;
    logic                 w_origin;
    logic                 w_in_run;
    logic                 w_pop;
    logic                 w_underflow;

    assign w_vis    = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_hs     = (r_h_cnt >= c_HS_BEGIN) && (r_h_cnt < c_HS_END);
    assign w_vs     = (r_v_cnt >= c_VS_BEGIN) && (r_v_cnt < c_VS_END);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!enable_in) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:      w_next_state = c_SYNC_WAIT;
                c_SYNC_WAIT: if (w_origin && !fifo_empty_in) w_next_state = c_RUN;
                c_RUN:       if (w_underflow) w_next_state = c_SYNC_WAIT;
                default:     w_next_state = c_IDLE;
            endcase
        end
    end

    // The cycle that leaves SYNC_WAIT for RUN already pops the first pixel.
    always_comb begin
        w_in_run    = enable_in && ((r_state == c_RUN) ||
                      ((r_state == c_SYNC_WAIT) && w_origin && !fifo_empty_in));
        w_pop       = w_in_run && w_vis && !fifo_empty_in;
        w_underflow = enable_in && (r_state == c_RUN) && w_vis && fifo_empty_in;
    end

    assign fifo_rd_ack_out = w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!enable_in || (r_state == c_IDLE)) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_MAX) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_MAX) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out       <= '0;
            hsync_out       <= 1'b1;
            vsync_out       <= 1'b1;
            active_out      <= 1'b0;
            frame_start_out <= 1'b0;
            underflow_out   <= 1'b0;
        end else if (!enable_in || (r_state == c_IDLE)) begin
            pixel_out       <= '0;
            hsync_out       <= 1'b1;
            vsync_out       <= 1'b1;
            active_out      <= 1'b0;
            frame_start_out <= 1'b0;
            underflow_out   <= 1'b0;
        end else begin
            pixel_out       <= w_pop ? fifo_data_in : '0;
            hsync_out       <= ~w_hs;
            vsync_out       <= ~w_vs;
            active_out      <= w_pop;
            frame_start_out <= w_pop && w_origin;
            underflow_out   <= w_underflow;
        end
    end

`ifdef UNDERFLOW_CNT_EN
    // Only the hard reset clears the count so it survives enable cycling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_count_out <= '0;
        end else if (w_underflow && (underflow_count_out != 16'hFFFF)) begin
            underflow_count_out <= underflow_count_out + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_vga_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_vga_reader
// Description : Directed bench for fifo_vga_reader on a tiny 8x6 raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_vga_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable_in;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          rd_ack;
    logic [DW-1:0] pixel_out;
    logic          hsync_out;
    logic          vsync_out;
    logic          active_out;
    logic          frame_start_out;
    logic          underflow_out;
`ifdef UNDERFLOW_CNT_EN
    logic [15:0]   uf_count;
`endif

    always #5 clk = ~clk;

    fifo_vga_reader #(
        .DATA_WIDTH(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_WIDTH(10)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable_in       (enable_in),
        .fifo_data_in    (fifo_data),
        .fifo_empty_in   (fifo_empty),
        .fifo_rd_ack_out (rd_ack),
        .pixel_out       (pixel_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .active_out      (active_out),
        .frame_start_out (frame_start_out),
`ifdef UNDERFLOW_CNT_EN
        .underflow_count_out (uf_count),
`endif
        .underflow_out   (underflow_out)
    );

    // Show-ahead FIFO model
    logic [DW-1:0] mem [0:63];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic flush = 1'b0;
    int   pop_count = 0;
    int   ack_empty_cnt = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (rd_ack) begin
            if (fifo_empty) begin
                ack_empty_cnt <= ack_empty_cnt + 1;
            end else begin
                rd_ptr    <= rd_ptr + 1;
                pop_count <= pop_count + 1;
            end
        end
    end

    logic [12:0] obs_vec;
    assign obs_vec = {pixel_out, active_out, hsync_out, vsync_out, frame_start_out, underflow_out};

    localparam logic [12:0] IDLE_VEC = 13'h00C;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Expected {pixel,active,hsync,vsync,frame_start,underflow} for raster index k
    // when popping runs from index rs (a frame origin) up to re.
    function automatic logic [12:0] exp_vec(input int k, input int rs, input int re,
                                            input int base, input int ufk);
        int   h;
        int   v;
        logic act;
        h   = k % 8;
        v   = (k / 8) % 6;
        act = (k >= rs) && (k < re) && (h < 4) && (v < 3);
        return {act ? 8'(base + v * 4 + h) : 8'h00, act,
                !(h == 5 || h == 6), (v != 4), (k == rs), (k == ufk)};
    endfunction

    task automatic run_window(input string tag, input int k0, input int k1,
                              input int rs, input int re, input int base, input int ufk);
        for (int k = k0; k < k1; k++) begin
            @(negedge clk);
            check($sformatf("%s k=%0d", tag, k), 32'(obs_vec), 32'(exp_vec(k, rs, re, base, ufk)));
        end
    endtask

    task automatic start();
        enable_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic stop(input string tag);
        enable_in = 1'b0;
        #1;
        check({tag, " ack_off"}, 32'(rd_ack), 32'd0);
        @(negedge clk);
        check({tag, " idle_out"}, 32'(obs_vec), 32'(IDLE_VEC));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    int p0;

    initial begin
        reset_n   = 1'b0;
        enable_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'(obs_vec), 32'(IDLE_VEC));
        check("reset ack", 32'(rd_ack), 32'd0);

        // Full frame from a preloaded FIFO
        for (int i = 1; i <= 12; i++) push(8'(i));
        p0 = pop_count;
        reset_n = 1'b1;
        @(negedge clk);
        run_window("full", 0, 48, 0, 48, 1, -1);
        check("full pops", 32'(pop_count - p0), 32'd12);
        stop("full");

        // Wait for data while syncs keep running
        p0 = pop_count;
        start();
        run_window("wait", 0, 20, 48, 96, 1, -1);
        check("wait pops", 32'(pop_count - p0), 32'd0);
        for (int i = 1; i <= 12; i++) push(8'(i));
        run_window("wait", 20, 96, 48, 96, 1, -1);
        check("wait pops total", 32'(pop_count - p0), 32'd12);
        stop("wait");

        // Underflow at pixel (2,1), resync two frames later
        p0 = pop_count;
        for (int i = 1; i <= 6; i++) push(8'(i));
        start();
        run_window("uflow", 0, 51, 0, 10, 1, 10);
        check("uflow pops", 32'(pop_count - p0), 32'd6);
        for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
        run_window("uflow", 51, 96, 0, 10, 1, 10);
        run_window("uflow", 96, 144, 96, 144, 8'h21, -1);
        check("uflow pops total", 32'(pop_count - p0), 32'd18);
        stop("uflow");

        // Disable in the middle of line 1
        p0 = pop_count;
        for (int i = 1; i <= 12; i++) push(8'(i));
        start();
        run_window("midoff", 0, 10, 0, 1000, 1, -1);
        stop("midoff");
        repeat (10) @(negedge clk);
        check("midoff still idle", 32'(obs_vec), 32'(IDLE_VEC));
        check("midoff pops", 32'(pop_count - p0), 32'd6);

`ifdef UNDERFLOW_CNT_EN
        reset_n = 1'b0;
        #1;
        check("ucnt reset", 32'(uf_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        push(8'h40);
        start();
        for (int f = 0; f < 3; f++) begin
            run_window("ucnt", f * 48, f * 48 + 20, f * 48, f * 48 + 1, 8'h40 + f, f * 48 + 1);
            push(8'(8'h41 + f));
            run_window("ucnt", f * 48 + 20, f * 48 + 48, f * 48, f * 48 + 1, 8'h40 + f, f * 48 + 1);
        end
        check("ucnt three", 32'(uf_count), 32'd3);
        stop("ucnt");
        check("ucnt kept by enable", 32'(uf_count), 32'd3);
        reset_n = 1'b0;
        #1;
        check("ucnt cleared", 32'(uf_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
`endif

        check("ack while empty", 32'(ack_empty_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
